rf_sort_ctrl: RTL and testbench



---
 rtl/rf_sort_ctrl_pkg.sv | 22 ++
 rtl/rf_sort_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_rf_sort_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_sort_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rf_sort_ctrl_pkg
//   Shared definitions for the register-file sort sequencer.
//   - state_t : 3-bit state encoding (ST_IDLE, ST_CMP, ST_SWA, ST_SWB, ST_FIN)
//   - rf_nent : number of register-file entries for a given address width
// -----------------------------------------------------------------------------
package rf_sort_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMP  = 3'd1,
    ST_SWA  = 3'd2,
    ST_SWB  = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

  // NENT = 1 << AW : entries covered by one sort.
  function automatic int rf_nent(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/rf_sort_ctrl.sv
// -----------------------------------------------------------------------------
// rf_sort_ctrl
//   In-place ascending unsigned bubble sort over all 2^AW entries of an
//   external register file, with early exit when a pass makes no swaps.
//   The block drives the two asynchronous read ports and the single write
//   port of the register file; the top level hands it the ports while busy=1.
//
// Ports
//   clk    : clock, all state changes on posedge
//   rst    : synchronous active-high reset
//   start  : level request, only sampled in IDLE
//   busy   : high in CMP/SWA/SWB, block owns the RF ports
//   done   : one-cycle pulse (FIN) when a sort completes
//   ra0    : RF read address 0 (= i)
//   ra1    : RF read address 1 (= i+1)
//   rd0    : RF read data 0, combinational from ra0
//   rd1    : RF read data 1, combinational from ra1
//   wa     : RF write address
//   wd     : RF write data
//   we     : RF write enable
//   cnt    : busy cycles of the last or current sort, saturating
// -----------------------------------------------------------------------------
module rf_sort_ctrl
  import rf_sort_ctrl_pkg::*;
#(
  parameter int AW = 5,
  parameter int DW = 16,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] ra0,
  output logic [AW-1:0] ra1,
  input  logic [DW-1:0] rd0,
  input  logic [DW-1:0] rd1,
  output logic [AW-1:0] wa,
  output logic [DW-1:0] wd,
  output logic          we,
  output logic [CW-1:0] cnt
);

  localparam int            NENT   = rf_nent(AW);
  localparam logic [AW-1:0] ONE_A  = AW'(1);
  localparam logic [AW-1:0] P_INIT = AW'(NENT - 1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  // Busy-cycle counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CW-1:0] cnt_sat_inc(input logic [CW-1:0] c);
    if (c == CNT_MAX)
      return c;
    else
      return c + CW'(1);
  endfunction

  // Control state
  state_t          state, state_nxt;
  logic [AW-1:0]   i_idx, i_nxt;
  logic [AW-1:0]   p_lim, p_nxt;
  logic            swapped, swapped_nxt;
  logic [CW-1:0]   cnt_r, cnt_nxt;

  // Operand pair captured in CMP, written back crosswise in SWA/SWB
  logic [DW-1:0]   a_p0, b_p0;

  logic [AW-1:0]   i_plus1;
  logic            advance;

  // i+1 never wraps because i+1 <= p <= 2^AW-1 whenever it is used.
  assign i_plus1 = i_idx + ONE_A;

  assign ra0 = i_idx;
  assign ra1 = i_plus1;
  assign cnt = cnt_r;

  // ---- next-state / output logic -------------------------------------------
  always_comb begin
    state_nxt   = state;
    i_nxt       = i_idx;
    p_nxt       = p_lim;
    swapped_nxt = swapped;
    cnt_nxt     = cnt_r;
    busy        = 1'b0;
    done        = 1'b0;
    we          = 1'b0;
    wa          = '0;
    wd          = '0;
    advance     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          i_nxt       = '0;
          p_nxt       = P_INIT;
          swapped_nxt = 1'b0;
          cnt_nxt     = '0;
          state_nxt   = ST_CMP;
        end
      end

      ST_CMP: begin
        busy    = 1'b1;
        cnt_nxt = cnt_sat_inc(cnt_r);
        // Unsigned compare; equal values fall through so the sort is stable.
        if (rd0 > rd1)
          state_nxt = ST_SWA;
        else
          advance = 1'b1;
      end

      ST_SWA: begin
        busy        = 1'b1;
        we          = 1'b1;
        wa          = i_idx;
        wd          = b_p0;
        swapped_nxt = 1'b1;
        cnt_nxt     = cnt_sat_inc(cnt_r);
        state_nxt   = ST_SWB;
      end

      ST_SWB: begin
        busy    = 1'b1;
        we      = 1'b1;
        wa      = i_plus1;
        wd      = a_p0;
        cnt_nxt = cnt_sat_inc(cnt_r);
        advance = 1'b1;
      end

      ST_FIN: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Step to the next pair, or close the pass. A pass with no swaps means
    // the array is sorted; p==1 means the last pass covered a single pair.
    if (advance) begin
      if (i_plus1 < p_lim) begin
        i_nxt     = i_plus1;
        state_nxt = ST_CMP;
      end else if (!swapped || (p_lim == ONE_A)) begin
        state_nxt = ST_FIN;
      end else begin
        p_nxt       = p_lim - ONE_A;
        i_nxt       = '0;
        swapped_nxt = 1'b0;
        state_nxt   = ST_CMP;
      end
    end
  end

  // ---- control registers ---------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      i_idx   <= '0;
      p_lim   <= P_INIT;
      swapped <= 1'b0;
      cnt_r   <= '0;
    end else begin
      state   <= state_nxt;
      i_idx   <= i_nxt;
      p_lim   <= p_nxt;
      swapped <= swapped_nxt;
      cnt_r   <= cnt_nxt;
    end
  end

  // ---- operand capture (data only, no reset) -------------------------------
  always_ff @(posedge clk) begin
    if (state == ST_CMP) begin
      a_p0 <= rd0;
      b_p0 <= rd1;
    end
  end

endmodule

// File: tb/tb_rf_sort_ctrl.sv
module tb_rf_sort_ctrl;

  localparam int AW_A = 2, DW_A = 16, CW_A = 16, N_A = 4;
  localparam int AW_B = 3, DW_B = 8,  CW_B = 4,  N_B = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // ---------------- instance A: 4 entries, 16-bit data ----------------
  logic            start_a, a_busy, a_done, a_we;
  logic [AW_A-1:0] a_ra0, a_ra1, a_wa;
  logic [DW_A-1:0] a_rd0, a_rd1, a_wd;
  logic [CW_A-1:0] a_cnt;
  logic [DW_A-1:0] mem_a [N_A];
  logic            ha_we;
  logic [AW_A-1:0] ha_wa;
  logic [DW_A-1:0] ha_wd;

  assign a_rd0 = mem_a[a_ra0];
  assign a_rd1 = mem_a[a_ra1];
  always_ff @(posedge clk)
    if (a_busy ? a_we : ha_we)
      mem_a[a_busy ? a_wa : ha_wa] <= a_busy ? a_wd : ha_wd;

  rf_sort_ctrl #(.AW(AW_A), .DW(DW_A), .CW(CW_A)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(a_busy), .done(a_done),
    .ra0(a_ra0), .ra1(a_ra1), .rd0(a_rd0), .rd1(a_rd1),
    .wa(a_wa), .wd(a_wd), .we(a_we), .cnt(a_cnt));

  // ---------------- instance B: 8 entries, 8-bit data, 4-bit counter ----
  logic            start_b, b_busy, b_done, b_we;
  logic [AW_B-1:0] b_ra0, b_ra1, b_wa;
  logic [DW_B-1:0] b_rd0, b_rd1, b_wd;
  logic [CW_B-1:0] b_cnt;
  logic [DW_B-1:0] mem_b [N_B];
  logic            hb_we;
  logic [AW_B-1:0] hb_wa;
  logic [DW_B-1:0] hb_wd;

  assign b_rd0 = mem_b[b_ra0];
  assign b_rd1 = mem_b[b_ra1];
  always_ff @(posedge clk)
    if (b_busy ? b_we : hb_we)
      mem_b[b_busy ? b_wa : hb_wa] <= b_busy ? b_wd : hb_wd;

  rf_sort_ctrl #(.AW(AW_B), .DW(DW_B), .CW(CW_B)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(b_busy), .done(b_done),
    .ra0(b_ra0), .ra1(b_ra1), .rd0(b_rd0), .rd1(b_rd1),
    .wa(b_wa), .wd(b_wd), .we(b_we), .cnt(b_cnt));

  // ---------------- reference model ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_v [8];
  int          exp_cyc, exp_wr;

  // Textbook bubble sort with early exit; each compare costs 1 cycle and
  // each swap 2 more cycles (two writes).
  task automatic model_sort(input int n);
    int p;
    bit sw;
    logic [15:0] t;
    exp_cyc = 0;
    exp_wr  = 0;
    p = n - 1;
    while (1) begin
      sw = 0;
      for (int k = 0; k < p; k++) begin
        exp_cyc++;
        if (exp_v[k] > exp_v[k+1]) begin
          t = exp_v[k]; exp_v[k] = exp_v[k+1]; exp_v[k+1] = t;
          exp_cyc += 2;
          exp_wr  += 2;
          sw = 1;
        end
      end
      if (!sw || p == 1) break;
      p--;
    end
  endtask

  task automatic set4(input logic [15:0] x0, x1, x2, x3);
    exp_v[0] = x0; exp_v[1] = x1; exp_v[2] = x2; exp_v[3] = x3;
  endtask

  task automatic preload_a();
    for (int k = 0; k < N_A; k++) begin
      @(negedge clk);
      ha_we = 1'b1; ha_wa = AW_A'(k); ha_wd = exp_v[k];
    end
    @(negedge clk);
    ha_we = 1'b0;
  endtask

  task automatic preload_b();
    for (int k = 0; k < N_B; k++) begin
      @(negedge clk);
      hb_we = 1'b1; hb_wa = AW_B'(k); hb_wd = exp_v[k][7:0];
    end
    @(negedge clk);
    hb_we = 1'b0;
  endtask

  task automatic check_mem_a(input string name);
    for (int k = 0; k < N_A; k++) begin
      n_checks++;
      if (mem_a[k] !== exp_v[k]) begin
        n_fail++;
        $display("FAIL %s rf[%0d]: got %0h expected %0h", name, k, mem_a[k], exp_v[k]);
      end
    end
  endtask

  // Pulse start, follow the sort to done and compare everything observable.
  task automatic run_a(input string name, input bit pulse_mid);
    int nbusy, nwe, ndone, done_at;
    nbusy = 0; nwe = 0; ndone = 0; done_at = -1;
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (pulse_mid && c == 1) start_a = 1'b1;
      if (pulse_mid && c == 2) start_a = 1'b0;
      if (a_busy) nbusy++;
      if (a_we) nwe++;
      if (a_done) begin
        ndone++; done_at = c;
        n_checks++;
        if (a_busy !== 1'b0) begin
          n_fail++; $display("FAIL %s busy_at_done: got %b expected 0", name, a_busy);
        end
        break;
      end
      @(negedge clk);
    end
    start_a = 1'b0;
    n_checks++;
    if (done_at != exp_cyc) begin
      n_fail++; $display("FAIL %s done_cycle: got %0d expected %0d", name, done_at, exp_cyc);
    end
    n_checks++;
    if (nbusy != exp_cyc) begin
      n_fail++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, nbusy, exp_cyc);
    end
    n_checks++;
    if (nwe != exp_wr) begin
      n_fail++; $display("FAIL %s we_cycles: got %0d expected %0d", name, nwe, exp_wr);
    end
    n_checks++;
    if (a_cnt !== CW_A'(exp_cyc)) begin
      n_fail++; $display("FAIL %s cnt: got %0d expected %0d", name, a_cnt, exp_cyc);
    end
    @(negedge clk);
    n_checks++;
    if (a_done !== 1'b0 || a_busy !== 1'b0 || a_cnt !== CW_A'(exp_cyc)) begin
      n_fail++;
      $display("FAIL %s after_done: got done=%b busy=%b cnt=%0d expected 0 0 %0d",
               name, a_done, a_busy, a_cnt, exp_cyc);
    end
    check_mem_a(name);
  endtask

  task automatic run_b(input string name);
    int nwe, done_at, exp_cnt;
    nwe = 0; done_at = -1;
    exp_cnt = (exp_cyc > 15) ? 15 : exp_cyc;
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (b_we) nwe++;
      if (b_done) begin done_at = c; break; end
      @(negedge clk);
    end
    n_checks++;
    if (done_at != exp_cyc) begin
      n_fail++; $display("FAIL %s done_cycle: got %0d expected %0d", name, done_at, exp_cyc);
    end
    n_checks++;
    if (nwe != exp_wr) begin
      n_fail++; $display("FAIL %s we_cycles: got %0d expected %0d", name, nwe, exp_wr);
    end
    n_checks++;
    if (b_cnt !== CW_B'(exp_cnt)) begin
      n_fail++; $display("FAIL %s cnt_sat: got %0d expected %0d", name, b_cnt, exp_cnt);
    end
    for (int k = 0; k < N_B; k++) begin
      n_checks++;
      if (mem_b[k] !== exp_v[k][7:0]) begin
        n_fail++;
        $display("FAIL %s rf[%0d]: got %0h expected %0h", name, k, mem_b[k], exp_v[k][7:0]);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({a_busy, a_done, a_we} !== 3'b000 || a_cnt !== '0) begin
      n_fail++; $display("FAIL reset_ctrl_a: got busy/done/we=%b%b%b cnt=%0d expected 000 0",
                         a_busy, a_done, a_we, a_cnt);
    end
    n_checks++;
    if (a_ra0 !== 2'd0 || a_ra1 !== 2'd1 || a_wa !== 2'd0 || a_wd !== 16'd0) begin
      n_fail++; $display("FAIL reset_addr_a: got ra0=%0d ra1=%0d wa=%0d wd=%0h expected 0 1 0 0",
                         a_ra0, a_ra1, a_wa, a_wd);
    end
    n_checks++;
    if ({b_busy, b_done, b_we} !== 3'b000 || b_cnt !== '0 || b_ra1 !== 3'd1) begin
      n_fail++; $display("FAIL reset_b: got busy/done/we=%b%b%b cnt=%0d ra1=%0d expected 000 0 1",
                         b_busy, b_done, b_we, b_cnt, b_ra1);
    end
    rst = 1'b0;
  endtask

  task automatic test_patterns();
    set4(16'd1, 16'd2, 16'd3, 16'd4); preload_a(); model_sort(N_A); run_a("sorted", 0);
    set4(16'd4, 16'd3, 16'd2, 16'd1); preload_a(); model_sort(N_A); run_a("reverse", 0);
    set4(16'd2, 16'd1, 16'd3, 16'd4); preload_a(); model_sort(N_A); run_a("one_swap", 0);
    set4(16'd5, 16'd5, 16'd0, 16'd5); preload_a(); model_sort(N_A); run_a("equal", 0);
    set4(16'hFFFF, 16'h0000, 16'h8000, 16'h7FFF); preload_a(); model_sort(N_A);
    run_a("unsigned", 0);
  endtask

  task automatic test_rst_mid();
    int seen, ndone;
    seen = 0; ndone = 0;
    set4(16'd4, 16'd3, 16'd2, 16'd1); preload_a();
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (a_we) begin seen = 1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (seen == 0 || a_wa !== 2'd0 || a_wd !== 16'd3) begin
      n_fail++; $display("FAIL rst_mid_swa: got seen=%0d wa=%0d wd=%0h expected 1 0 3",
                         seen, a_wa, a_wd);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (a_busy !== 1'b0 || a_we !== 1'b0 || a_cnt !== '0 || a_done !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_state: got busy=%b we=%b cnt=%0d done=%b expected 0 0 0 0",
                         a_busy, a_we, a_cnt, a_done);
    end
    for (int c = 0; c < 6; c++) begin
      if (a_done) ndone++;
      @(negedge clk);
    end
    n_checks++;
    if (ndone != 0) begin
      n_fail++; $display("FAIL rst_mid_no_done: got %0d pulses expected 0", ndone);
    end
    // Only the SWA write (smaller value into entry 0) was committed.
    set4(16'd3, 16'd3, 16'd2, 16'd1);
    check_mem_a("rst_mid_rf");
    set4(16'd4, 16'd3, 16'd2, 16'd1); preload_a(); model_sort(N_A); run_a("after_rst", 0);
  endtask

  task automatic test_start_busy();
    set4(16'd4, 16'd3, 16'd2, 16'd1); preload_a(); model_sort(N_A);
    run_a("start_busy", 1);
  endtask

  task automatic test_start_hold();
    int done_at, first_cyc;
    done_at = -1;
    set4(16'd3, 16'd1, 16'd2, 16'd4); preload_a(); model_sort(N_A);
    first_cyc = exp_cyc;
    @(negedge clk) start_a = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 200; c++) begin
      if (a_done) begin done_at = c; break; end
      @(negedge clk);
    end
    n_checks++;
    if (done_at != first_cyc || a_cnt !== CW_A'(first_cyc)) begin
      n_fail++; $display("FAIL hold_first: got done_at=%0d cnt=%0d expected %0d %0d",
                         done_at, a_cnt, first_cyc, first_cyc);
    end
    @(negedge clk);
    n_checks++;
    if (a_busy !== 1'b0 || a_done !== 1'b0 || a_cnt !== CW_A'(first_cyc)) begin
      n_fail++; $display("FAIL hold_idle: got busy=%b done=%b cnt=%0d expected 0 0 %0d",
                         a_busy, a_done, a_cnt, first_cyc);
    end
    @(negedge clk);
    n_checks++;
    if (a_busy !== 1'b1 || a_cnt !== '0) begin
      n_fail++; $display("FAIL hold_restart: got busy=%b cnt=%0d expected 1 0", a_busy, a_cnt);
    end
    start_a = 1'b0;
    model_sort(N_A);
    done_at = -1;
    for (int c = 0; c < 200; c++) begin
      if (a_done) begin done_at = c; break; end
      @(negedge clk);
    end
    n_checks++;
    if (done_at != exp_cyc || a_cnt !== CW_A'(exp_cyc)) begin
      n_fail++; $display("FAIL hold_second: got done_at=%0d cnt=%0d expected %0d %0d",
                         done_at, a_cnt, exp_cyc, exp_cyc);
    end
    check_mem_a("hold_rf");
  endtask

  task automatic test_random();
    for (int it = 0; it < 16; it++) begin
      for (int k = 0; k < N_A; k++)
        exp_v[k] = (it % 2 == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      preload_a(); model_sort(N_A); run_a("random_a", 0);
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < N_B; k++) exp_v[k] = 16'(N_B - k);
    preload_b(); model_sort(N_B); run_b("sat_reverse");
    for (int it = 0; it < 4; it++) begin
      for (int k = 0; k < N_B; k++) exp_v[k] = 16'($urandom_range(0, 255));
      preload_b(); model_sort(N_B); run_b("random_b");
    end
    exp_v[0] = 16'd1; exp_v[1] = 16'd2; exp_v[2] = 16'd3; exp_v[3] = 16'd4;
    exp_v[4] = 16'd5; exp_v[5] = 16'd6; exp_v[6] = 16'd8; exp_v[7] = 16'd7;
    preload_b(); model_sort(N_B); run_b("nosat_b");
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    ha_we = 1'b0; ha_wa = '0; ha_wd = '0;
    hb_we = 1'b0; hb_wa = '0; hb_wd = '0;
    test_reset();
    test_patterns();
    test_rst_mid();
    test_start_busy();
    test_start_hold();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
